// File: rtl/l2_event_sched.sv
// Event scheduler feeding the 3-neuron L2 layer: captures L1 spike requests, issues them
// one at a time in round-robin order, and frames each event with a spike-output window.
module l2_event_sched #(
    parameter int P_WIN    = 2,
    parameter int P_GAP    = 4,
    parameter int P_DROP_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [6:1]          i_req,
    input  logic                i_enable,
    output logic [6:1]          o_event,
    output logic                o_sp_control,
    output logic                o_busy,
    output logic [6:1]          o_pending,
    output logic [P_DROP_W-1:0] o_drop_cnt,
    output logic [1:0]          o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    localparam int DW = P_DROP_W + 3;
    localparam logic [3:0] L_WIN_LD = 4'(P_WIN - 1);
    localparam logic [3:0] L_GAP_LD = (P_GAP == 0) ? 4'd0 : 4'(P_GAP - 1);

    state_t                r_state;
    logic [6:1]            r_pending;
    logic [2:0]            r_last;
    logic [3:0]            r_cnt;
    logic                  r_en;
    logic [6:1]            r_event;
    logic                  r_sp;
    logic                  r_busy;
    logic [P_DROP_W-1:0]   r_drop;

    state_t                w_state_next;
    logic [6:1]            w_grant;
    logic [2:0]            w_grant_idx;
    logic                  w_issue;
    logic [6:1]            w_clr;
    logic [6:1]            w_drop_bits;
    logic [2:0]            w_drop_n;
    logic [DW-1:0]         w_drop_sum;
    logic [P_DROP_W-1:0]   w_drop_next;
    logic [3:0]            w_cnt_next;
    logic [6:1]            w_event_next;
    logic                  w_sp_next;
    logic                  w_busy_next;

    // Round-robin search starting just after the last issued source.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_idx = r_last;
        for (int k = 1; k <= 6; k++) begin
            idx = ((int'(r_last) + k - 1) % 6) + 1;
            if (w_grant == '0 && r_pending[3'(idx)]) begin
                w_grant[3'(idx)] = 1'b1;
                w_grant_idx      = 3'(idx);
            end
        end
    end

    assign w_issue     = (r_state == S_IDLE) && r_en && (r_pending != '0);
    assign w_clr       = w_issue ? w_grant : '0;
    assign w_drop_bits = i_req & r_pending & ~w_clr;

    always_comb begin
        w_drop_n = '0;
        for (int n = 1; n <= 6; n++) begin
            w_drop_n = w_drop_n + 3'(w_drop_bits[3'(n)]);
        end
    end

    assign w_drop_sum  = DW'(r_drop) + DW'(w_drop_n);
    assign w_drop_next = (w_drop_sum[DW-1:P_DROP_W] != '0) ? '1 : w_drop_sum[P_DROP_W-1:0];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; WAIT and GAP share the single down-counter
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_next = (P_GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (r_cnt == 4'd0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic, computed one cycle ahead so every output leaves a flop
    always_comb begin
        w_event_next = w_issue ? w_grant : '0;
        w_sp_next    = (w_state_next == S_WAIT);
        w_busy_next  = (w_state_next != S_IDLE);
        w_cnt_next   = r_cnt;
        case (r_state)
            S_ISSUE: w_cnt_next = L_WIN_LD;
            S_WAIT:  w_cnt_next = (r_cnt == 4'd0) ? L_GAP_LD : r_cnt - 4'd1;
            S_GAP:   w_cnt_next = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
            r_last    <= 3'd6;
            r_cnt     <= '0;
            r_en      <= 1'b0;
            r_event   <= '0;
            r_sp      <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | i_req;
            if (w_issue) r_last <= w_grant_idx;
            r_cnt     <= w_cnt_next;
            r_en      <= i_enable;
            r_event   <= w_event_next;
            r_sp      <= w_sp_next;
            r_busy    <= w_busy_next;
            r_drop    <= w_drop_next;
        end
    end

    assign o_event      = r_event;
    assign o_sp_control = r_sp;
    assign o_busy       = r_busy;
    assign o_pending    = r_pending;
    assign o_drop_cnt   = r_drop;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_l2_event_sched.sv
// Bench for l2_event_sched: three instances (defaults, 2-bit drop counter, zero gap) run in
// lockstep against a timing-equation reference model.
module tb_l2_event_sched;
    localparam int P_WIN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:1] i_req = '0;
    logic       i_enable = 1'b0;

    logic [6:1] ev[3];
    logic       sp[3];
    logic       busy[3];
    logic [6:1] pend[3];
    logic [1:0] st[3];
    logic [7:0] drop0;
    logic [1:0] drop1;
    logic [7:0] drop2;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset block
    always #5 clk = ~clk;

    l2_event_sched #(.P_WIN(2), .P_GAP(4), .P_DROP_W(8)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_enable(i_enable),
        .o_event(ev[0]), .o_sp_control(sp[0]), .o_busy(busy[0]), .o_pending(pend[0]),
        .o_drop_cnt(drop0), .o_dbg_state(st[0]));
    l2_event_sched #(.P_WIN(2), .P_GAP(4), .P_DROP_W(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_enable(i_enable),
        .o_event(ev[1]), .o_sp_control(sp[1]), .o_busy(busy[1]), .o_pending(pend[1]),
        .o_drop_cnt(drop1), .o_dbg_state(st[1]));
    l2_event_sched #(.P_WIN(2), .P_GAP(0), .P_DROP_W(8)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_enable(i_enable),
        .o_event(ev[2]), .o_sp_control(sp[2]), .o_busy(busy[2]), .o_pending(pend[2]),
        .o_drop_cnt(drop2), .o_dbg_state(st[2]));

    // reference model: event time E per instance, outputs derived from the timing rules
    int         pg[3]   = '{4, 4, 0};
    int         dmax[3] = '{255, 3, 255};
    int         cyc;
    int         m_e[3];
    logic [6:1] m_ev[3];
    logic [6:1] m_pend[3];
    int         m_last[3];
    bit         m_en[3];
    int         m_drop[3];

    function automatic void model_reset();
        cyc = 0;
        for (int d = 0; d < 3; d++) begin
            m_e[d] = -100; m_ev[d] = '0; m_pend[d] = '0;
            m_last[d] = 6; m_en[d] = 1'b0; m_drop[d] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [6:1] r, input bit e);
        for (int d = 0; d < 3; d++) begin
            logic [6:1] iss = '0;
            int cnt = 0;
            if (cyc >= m_e[d] + P_WIN + pg[d] + 1 && m_en[d] && m_pend[d] != '0) begin
                for (int k = 1; k <= 6; k++) begin
                    int idx = ((m_last[d] + k - 1) % 6) + 1;
                    if (iss == '0 && m_pend[d][idx]) begin
                        iss[idx] = 1'b1;
                        m_last[d] = idx;
                    end
                end
                m_e[d] = cyc + 1;
                m_ev[d] = iss;
            end
            for (int n = 1; n <= 6; n++)
                if (r[n] && m_pend[d][n] && !iss[n]) cnt++;
            m_drop[d] = (m_drop[d] + cnt > dmax[d]) ? dmax[d] : m_drop[d] + cnt;
            m_pend[d] = (m_pend[d] & ~iss) | r;
            m_en[d] = e;
        end
        cyc++;
    endfunction

    function automatic logic [6:1] exp_ev(input int d);
        return (cyc == m_e[d]) ? m_ev[d] : 6'b0;
    endfunction
    function automatic logic exp_sp(input int d);
        return (cyc >= m_e[d] + 1) && (cyc <= m_e[d] + P_WIN);
    endfunction
    function automatic logic exp_busy(input int d);
        return (cyc >= m_e[d]) && (cyc <= m_e[d] + P_WIN + pg[d]);
    endfunction
    function automatic int onehot_idx(input logic [6:1] v);
        for (int n = 1; n <= 6; n++) if (v[n]) return n;
        return 0;
    endfunction

    // driver tasks
    task automatic tick(input logic [6:1] r, input bit e);
        i_req = r; i_enable = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req = '0; i_enable = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (ev[d] !== 6'b0 || sp[d] !== 1'b0 || busy[d] !== 1'b0 || pend[d] !== 6'b0) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: ev=%b sp=%b busy=%b pend=%b, need all 0", d, ev[d], sp[d], busy[d], pend[d]);
            end
        end
        n_vec++;
        if (drop0 !== 8'd0 || drop1 !== 2'd0 || drop2 !== 8'd0) begin
            n_err++;
            $display("FAIL reset_drop: %0d %0d %0d, need 0", drop0, drop1, drop2);
        end
    endtask

    task automatic test_single();
        int ev_cyc = -1;
        do_reset();
        tick(6'b000100, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(6'b0, 1'b1);
            if (ev[0] != 6'b0) ev_cyc = cyc;
            n_vec++;
            if (ev[0] !== exp_ev(0) || sp[0] !== exp_sp(0) || busy[0] !== exp_busy(0)) begin
                n_err++;
                $display("FAIL single_cycle%0d: ev=%b sp=%b busy=%b, need ev=%b sp=%b busy=%b", cyc, ev[0], sp[0], busy[0], exp_ev(0), exp_sp(0), exp_busy(0));
            end
        end
        n_vec++;
        if (ev_cyc !== 2 || drop0 !== 8'd0) begin
            n_err++;
            $display("FAIL single_latency: event cycle %0d drop %0d, need cycle 2 drop 0", ev_cyc, drop0);
        end
    endtask

    task automatic test_burst();
        int order[$];
        int when[$];
        do_reset();
        tick(6'b111111, 1'b1);
        for (int i = 0; i < 45; i++) begin
            tick(6'b0, 1'b1);
            if (ev[0] != 6'b0) begin order.push_back(onehot_idx(ev[0])); when.push_back(cyc); end
            n_vec++;
            if (ev[0] !== exp_ev(0) || sp[0] !== exp_sp(0) || pend[0] !== m_pend[0]) begin
                n_err++;
                $display("FAIL burst_cycle%0d: ev=%b sp=%b pend=%b, need ev=%b sp=%b pend=%b", cyc, ev[0], sp[0], pend[0], exp_ev(0), exp_sp(0), m_pend[0]);
            end
        end
        n_vec++;
        if (order.size() != 6) begin
            n_err++;
            $display("FAIL burst_count: %0d events, need 6", order.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_vec++;
                if (order[k] != k + 1 || when[k] != 2 + 8 * k) begin
                    n_err++;
                    $display("FAIL burst_order%0d: src %0d at cycle %0d, need src %0d at cycle %0d", k, order[k], when[k], k + 1, 2 + 8 * k);
                end
            end
        end
        n_vec++;
        if (pend[0] !== 6'b0) begin
            n_err++;
            $display("FAIL burst_drain: pend=%b, need 000000", pend[0]);
        end
    endtask

    task automatic test_wrap();
        int order[$];
        do_reset();
        tick(6'b010000, 1'b1);
        for (int i = 0; i < 9; i++) tick(6'b0, 1'b1);
        tick(6'b100001, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(6'b0, 1'b1);
            if (ev[0] != 6'b0) order.push_back(onehot_idx(ev[0]));
            n_vec++;
            if (ev[0] !== exp_ev(0)) begin
                n_err++;
                $display("FAIL wrap_cycle%0d: ev=%b need %b", cyc, ev[0], exp_ev(0));
            end
        end
        n_vec++;
        if (order.size() != 2 || order[0] != 6 || order[1] != 1) begin
            n_err++;
            $display("FAIL wrap_order: got %0d events first=%0d, need 6 then 1", order.size(), (order.size() > 0) ? order[0] : 0);
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(6'b000100, 1'b0);
            n_vec++;
            if (ev[1] !== 6'b0 || int'(drop1) != m_drop[1]) begin
                n_err++;
                $display("FAIL drop_cycle%0d: ev=%b drop=%0d, need ev=0 drop=%0d", cyc, ev[1], drop1, m_drop[1]);
            end
        end
        n_vec++;
        if (drop1 !== 2'd3 || drop0 !== 8'd4 || pend[1] !== 6'b000100) begin
            n_err++;
            $display("FAIL drop_saturate: drop1=%0d drop0=%0d pend=%b, need 3 4 000100", drop1, drop0, pend[1]);
        end
        tick(6'b0, 1'b1);
        n_vec++;
        if (ev[1] !== 6'b0) begin
            n_err++;
            $display("FAIL drop_enable_early: ev=%b need 000000", ev[1]);
        end
        tick(6'b0, 1'b1);
        n_vec++;
        if (ev[1] !== 6'b000100 || drop1 !== 2'd3) begin
            n_err++;
            $display("FAIL drop_enable_issue: ev=%b drop=%0d, need 000100 3", ev[1], drop1);
        end
    endtask

    task automatic test_same_edge();
        int ev_cyc = -1;
        do_reset();
        tick(6'b000001, 1'b1);
        tick(6'b000001, 1'b1);
        n_vec++;
        if (ev[0] !== 6'b000001 || pend[0] !== 6'b000001 || drop0 !== 8'd0) begin
            n_err++;
            $display("FAIL same_edge: ev=%b pend=%b drop=%0d, need 000001 000001 0", ev[0], pend[0], drop0);
        end
        for (int i = 0; i < 10; i++) begin
            tick(6'b0, 1'b1);
            if (ev[0] == 6'b000001) ev_cyc = cyc;
        end
        n_vec++;
        if (ev_cyc != 10) begin
            n_err++;
            $display("FAIL same_edge_reissue: cycle %0d, need 10", ev_cyc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(6'b000010, 1'b1);
        tick(6'b0, 1'b1);
        tick(6'b0, 1'b1);
        n_vec++;
        if (sp[0] !== 1'b1 || busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_window: sp=%b busy=%b, need 1 1", sp[0], busy[0]);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (sp[0] !== 1'b0 || busy[0] !== 1'b0 || ev[0] !== 6'b0 || pend[0] !== 6'b0 || drop0 !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: sp=%b busy=%b ev=%b pend=%b", sp[0], busy[0], ev[0], pend[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick(6'b001000, 1'b1);
        tick(6'b0, 1'b1);
        n_vec++;
        if (ev[0] !== 6'b001000) begin
            n_err++;
            $display("FAIL post_reset_issue: ev=%b need 001000", ev[0]);
        end
    endtask

    task automatic test_gap0();
        int when[$];
        do_reset();
        tick(6'b111111, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick(6'b0, 1'b1);
            if (ev[2] != 6'b0) when.push_back(cyc);
            n_vec++;
            if (ev[2] !== exp_ev(2) || sp[2] !== exp_sp(2) || busy[2] !== exp_busy(2)) begin
                n_err++;
                $display("FAIL gap0_cycle%0d: ev=%b sp=%b busy=%b, need %b %b %b", cyc, ev[2], sp[2], busy[2], exp_ev(2), exp_sp(2), exp_busy(2));
            end
        end
        n_vec++;
        if (when.size() != 6) begin
            n_err++;
            $display("FAIL gap0_count: %0d events, need 6", when.size());
        end else begin
            for (int k = 1; k < 6; k++) begin
                n_vec++;
                if (when[k] - when[k-1] != 4) begin
                    n_err++;
                    $display("FAIL gap0_spacing%0d: %0d, need 4", k, when[k] - when[k-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        int dv[3];
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [6:1] r;
            bit e;
            r = '0;
            for (int n = 1; n <= 6; n++) r[n] = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 7) != 0);
            tick(r, e);
            dv[0] = int'(drop0); dv[1] = int'(drop1); dv[2] = int'(drop2);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (ev[d] !== exp_ev(d) || sp[d] !== exp_sp(d) || busy[d] !== exp_busy(d) ||
                    pend[d] !== m_pend[d] || dv[d] != m_drop[d] || (st[d] != 2'd0) !== exp_busy(d)) begin
                    n_err++;
                    $display("FAIL random_dut%0d_cycle%0d: ev=%b sp=%b busy=%b pend=%b drop=%0d, need %b %b %b %b %0d",
                             d, cyc, ev[d], sp[d], busy[d], pend[d], dv[d], exp_ev(d), exp_sp(d), exp_busy(d), m_pend[d], m_drop[d]);
                end
                n_vec++;
                if (ev[d] != 6'b0 && sp[d] == 1'b1) begin
                    n_err++;
                    $display("FAIL random_overlap_dut%0d_cycle%0d: ev=%b with sp=1, need no overlap", d, cyc, ev[d]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_drop();
        test_same_edge();
        test_reset_mid();
        test_gap0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/l2_event_sched.md
# l2_event_sched

Event scheduler between the layer-1 spike outputs and the 3-neuron L2 layer. Captures up to six asynchronous-in-time spike requests, serialises them into one-hot L2 input events with round-robin fairness, and drives the spike-output control window for each event. Guarantees the L2 neurons and their spike-output generator never see overlapping events. Counts requests lost to collisions.

## Interface
- P_WIN, 2: cycles `o_sp_control` stays high after each event; legal range 1–15.
- P_GAP, 4: idle guard cycles after the window before the next issue; legal range 0–15.
- P_DROP_W, 8: width of the drop counter.
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_req  in  6 [6:1]  spike request per L1 source; sampled every cycle, level = one request per high cycle.
- i_enable  in  1  permits new issues from IDLE.
- o_event  out  6 [6:1]  one-hot event to L2; high for exactly one cycle per issue.
- o_sp_control  out  1  spike-output window control to L2.
- o_busy  out  1  high whenever the FSM is not IDLE.
- o_pending  out  6 [6:1]  captured, not-yet-issued requests.
- o_drop_cnt  out  P_DROP_W  saturating count of lost requests.

## Operation
- Pending register: bit n is set on `i_req[n]`. It is cleared on the edge that issues n. A set and a clear in the same edge leave the bit set; this is a new request, not a drop.
- Drop: `i_req[n]` high while `pending[n]` is high and n is not being issued that edge. `o_drop_cnt` increments by the number of such bits that edge (0–6) and saturates at all-ones.
- Round-robin pointer `last` (1..6) holds the last issued index. The search order is last+1 … 6, then 1 … last. Reset value is 6, so the first search starts at 1.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE: if `i_enable` and pending≠0, grant the winner, clear its pending bit, update `last`, and go to ISSUE. Otherwise stay.
  - ISSUE: one cycle. `o_event` is the registered one-hot grant. Go to WAIT.
  - WAIT: P_WIN cycles with `o_sp_control`=1. Then go to GAP, or to IDLE if P_GAP=0.
  - GAP: P_GAP cycles. Then go to IDLE.
- `i_enable` low blocks only the IDLE→ISSUE transition. A sequence already in progress completes, and requests continue to be captured.
- All outputs are registered. `o_busy` = (state≠IDLE).
- One down-counter, 4 bits, is shared by WAIT and GAP.

## Timing
- Reset value of every output is 0. Reset also sets state=IDLE, pending=0, `last`=6, and the window counter to 0.
- Reset asserted mid-sequence clears everything immediately, including any `o_event` or `o_sp_control` pulse. After release the block starts in IDLE with nothing pending.
- Latency: `i_req[n]` high in cycle c → `o_pending[n]` high in c+1 → `o_event[n]` high in c+2 (block idle and enabled).
- For an event in cycle E:
  - `o_sp_control` is high in cycles E+1 … E+P_WIN.
  - IDLE is reached in cycle E+P_WIN+P_GAP+1.
  - The earliest next event is at E+P_WIN+P_GAP+2. With defaults, the minimum spacing is 8 cycles.
- Throughput limit: one event per P_WIN+P_GAP+2 cycles. Excess load accumulates in pending; repeats on an already-pending source are dropped.
- Simultaneous requests on multiple bits are all captured in the same cycle and issued in round-robin order.
- `o_event` is never high in the same cycle as `o_sp_control`.

## Test plan
- Single request: after reset, pulse `i_req`=6'b000100 in cycle 0 → `o_event`=000100 in cycle 2 only; `o_sp_control` high in cycles 3–4; `o_busy` high in cycles 2–8; `o_drop_cnt`=0.
- Burst fairness: `i_req`=6'b111111 for one cycle → `o_event` order 1,2,3,4,5,6, at cycles 2,10,18,26,34,42; pending drains to 0.
- Round-robin wrap: issue source 5, then raise bits 1 and 6 together → 6 issues before 1.
- Drop and saturation, with P_DROP_W=2:
  - Hold `i_enable`=0 and `i_req[3]` high for 5 cycles → `o_drop_cnt` reaches 3 and saturates; `o_pending`=000100; no event.
  - Then raise `i_enable` → `o_event`=000100 two cycles later (registered enable sampled in IDLE, then ISSUE).
- Same-edge set/clear: re-request source 1 on the edge it is issued → `pending[1]` stays 1, `o_drop_cnt` is unchanged, and source 1 is issued again after the gap.
- Reset mid-window, plus P_GAP=0:
  - Assert `i_rst` during WAIT → all outputs go to 0 asynchronously, and the next request after release is issued with the 2-cycle latency.
  - With P_GAP=0, events are spaced exactly P_WIN+2 = 4 cycles apart.
